// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    // Default first fetch address after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_REQ  = 2'd1,
        FS_RESP = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_e;

    // Redirect sources, indexed by priority (lower index wins)
    localparam int NUM_REDIR = 3;
    localparam int PRI_TRAP  = 0;
    localparam int PRI_FLUSH = 1;
    localparam int PRI_BR    = 2;

    // Force a fetch target onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port and decode handshake of the fetch sequencer.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    // Fetch sequencer side
    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_inst,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_inst,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready
    );
endinterface

// File: rtl/fetch_ctrl_redirect_arb.sv
// Priority select of trap/flush/branch redirects plus the pending-target
// register that holds a redirect until the in-flight fetch retires.
module fetch_ctrl_redirect_arb
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        capture_en,
    input  logic        pend_clr,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        pend_valid,
    output logic [31:0] pend_pc
);
    logic [NUM_REDIR-1:0] src_req;
    logic [31:0]          src_tgt [NUM_REDIR];
    logic [31:0]          src_tgt_al [NUM_REDIR];

    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    assign src_req[PRI_TRAP]  = trap_req;
    assign src_req[PRI_FLUSH] = flush_req;
    assign src_req[PRI_BR]    = br_req;
    assign src_tgt[PRI_TRAP]  = trap_vec;
    assign src_tgt[PRI_FLUSH] = flush_pc;
    assign src_tgt[PRI_BR]    = br_target;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REDIR; gi++) begin : g_align
            assign src_tgt_al[gi] = align_word(src_tgt[gi]);
        end
    endgenerate

    // Walk from lowest to highest priority so the highest active source wins
    always_comb begin
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                redir_valid = 1'b1;
                redir_pc    = src_tgt_al[i];
            end
        end
    end

    // Pending target: later redirects overwrite; retirement clears it
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        if (pend_clr) begin
            pend_valid_d = 1'b0;
        end else if (capture_en && redir_valid) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redir_pc;
        end
    end

    // Pending register update
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_pc    = pend_pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs a single-outstanding
// request/grant/response port and presents fetched words to decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           trap_req,
    input  logic [31:0]    trap_vec,
    input  logic           flush_req,
    input  logic [31:0]    flush_pc,
    input  logic           br_req,
    input  logic [31:0]    br_target,
    fetch_ctrl_if.master   bus,
    output logic [31:0]    pc
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;

    logic         redir_valid;
    logic [31:0]  redir_pc;
    logic         pend_valid;
    logic [31:0]  pend_pc;
    logic         capture_en;
    logic         discard;
    logic         pend_clr;
    logic [31:0]  retire_pc;

    // Redirects are only held while a memory transaction is open
    assign capture_en = (state_q == FS_REQ) || (state_q == FS_RESP);
    // A redirect on the retiring cycle itself also kills the response
    assign discard    = drop_q || redir_valid;
    assign pend_clr   = (state_q == FS_RESP) && bus.imem_rvalid && discard;
    // Newest redirect wins over the held one
    assign retire_pc  = (redir_valid || !pend_valid) ? redir_pc : pend_pc;

    fetch_ctrl_redirect_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .trap_req   (trap_req),
        .trap_vec   (trap_vec),
        .flush_req  (flush_req),
        .flush_pc   (flush_pc),
        .br_req     (br_req),
        .br_target  (br_target),
        .capture_en (capture_en),
        .pend_clr   (pend_clr),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .pend_valid (pend_valid),
        .pend_pc    (pend_pc)
    );

    // Next-state, PC and fetch-buffer selection
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        if (capture_en && redir_valid) begin
            drop_d = 1'b1;
        end
        case (state_q)
            FS_BOOT: state_d = FS_REQ;
            FS_REQ: begin
                if (bus.imem_gnt) begin
                    state_d = FS_RESP;
                end
            end
            FS_RESP: begin
                if (bus.imem_rvalid) begin
                    if (discard) begin
                        pc_d    = retire_pc;
                        drop_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        if_inst_d = bus.imem_rdata;
                        if_pc_d   = pc_q;
                        state_d   = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (redir_valid) begin
                    pc_d    = redir_pc;
                    state_d = FS_REQ;
                end else if (bus.if_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_BOOT;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FS_BOOT;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            if_pc_q   <= 32'h0;
            if_inst_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
        end
    end

    assign bus.imem_req  = (state_q == FS_REQ);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (state_q == FS_HOLD);
    assign bus.if_pc     = if_pc_q;
    assign bus.if_inst   = if_inst_q;
    assign pc            = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: memory responder, decode driver and a
// presentation-order reference model, all stepped from one initial block.
module tb_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req, flush_req, br_req;
    logic [31:0] trap_vec, flush_pc, br_target;
    logic [31:0] pc;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .trap_req (trap_req),
        .trap_vec (trap_vec),
        .flush_req(flush_req),
        .flush_pc (flush_pc),
        .br_req   (br_req),
        .br_target(br_target),
        .bus      (bus),
        .pc       (pc)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // staged inputs for the next cycle
    logic        rst_s = 1'b1, ready_s = 1'b0;
    logic        trap_s = 1'b0, flush_s = 1'b0, br_s = 1'b0;
    logic [31:0] trap_v = 0, flush_v = 0, br_v = 0;

    // memory responder state
    int          gnt_delay = 0, rv_delay = 0;
    logic        mem_rand = 1'b0, keep_on_rst = 1'b0;
    logic        pending = 1'b0, g_started = 1'b0;
    int          rv_cnt = 0, g_cnt = 0, g_need = 0;
    logic [31:0] resp_addr = 0;

    // reference model state
    logic        prev_rst = 1'b1, showing = 1'b0, expect_low = 1'b0;
    logic        have_redir = 1'b1;
    logic [31:0] redir_tgt = RST_PC, last_pc = 0, last_inst = 0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [31:0] prev_addr = 0;
    int          idle_cnt = 0, consumed = 0;

    logic [31:0] gnt_addr_q[$];
    int          gnt_cyc_q[$];
    logic [31:0] pres_pc_q[$];
    int          pres_cyc_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic mem_drive();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        if (rst && !keep_on_rst) begin
            pending   = 1'b0;
            g_cnt     = 0;
            g_started = 1'b0;
        end else if (pending) begin
            if (rv_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(resp_addr);
                pending = 1'b0;
            end else begin
                rv_cnt--;
            end
        end else if (bus.imem_req === 1'b1) begin
            if (!g_started) begin
                g_need    = mem_rand ? int'($urandom_range(0, 3)) : gnt_delay;
                g_started = 1'b1;
            end
            if (g_cnt >= g_need) begin
                bus.imem_gnt = 1'b1;
                pending   = 1'b1;
                resp_addr = bus.imem_addr;
                rv_cnt    = mem_rand ? int'($urandom_range(0, 3)) : rv_delay;
                g_cnt     = 0;
                g_started = 1'b0;
                gnt_addr_q.push_back(bus.imem_addr);
                gnt_cyc_q.push_back(cyc);
            end else begin
                g_cnt++;
            end
        end
    endtask

    // Model: each presented instruction is at the last redirect target seen
    // since the previous presentation, otherwise at the previous PC + 4.
    task automatic monitor();
        logic [31:0] exp_pc, t;
        logic        redir;
        if (prev_rst) begin
            showing = 1'b0; expect_low = 1'b0; have_redir = 1'b1;
            redir_tgt = RST_PC; idle_cnt = 0;
        end else begin
            redir = trap_req | flush_req | br_req;
            if (expect_low) begin
                tests_run++;
                if (bus.if_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL valid_drop: if_valid=%b required 0 (cycle %0d)", bus.if_valid, cyc);
                end
                expect_low = 1'b0;
            end
            if (showing && bus.if_valid !== 1'b1) begin
                tests_run++; tests_failed++;
                $display("FAIL valid_lost: if_valid=%b required 1 (cycle %0d)", bus.if_valid, cyc);
                showing = 1'b0;
            end
            if (bus.if_valid === 1'b1) begin
                idle_cnt = 0;
                if (!showing) begin
                    exp_pc = have_redir ? redir_tgt : last_pc + 32'd4;
                    tests_run++;
                    if (bus.if_pc !== exp_pc) begin
                        tests_failed++;
                        $display("FAIL pres_pc: if_pc=%h required %h (cycle %0d)", bus.if_pc, exp_pc, cyc);
                    end
                    tests_run++;
                    if (bus.if_inst !== mem_word(bus.if_pc)) begin
                        tests_failed++;
                        $display("FAIL pres_inst: if_inst=%h required %h (cycle %0d)", bus.if_inst, mem_word(bus.if_pc), cyc);
                    end
                    showing = 1'b1; have_redir = 1'b0;
                    last_pc = bus.if_pc; last_inst = bus.if_inst;
                    pres_pc_q.push_back(bus.if_pc);
                    pres_cyc_q.push_back(cyc);
                end else begin
                    tests_run++;
                    if (bus.if_pc !== last_pc || bus.if_inst !== last_inst) begin
                        tests_failed++;
                        $display("FAIL hold_stable: pc/inst=%h/%h required %h/%h", bus.if_pc, bus.if_inst, last_pc, last_inst);
                    end
                end
            end else begin
                idle_cnt++;
            end
            if (redir) begin
                if (trap_req) t = trap_vec;
                else if (flush_req) t = flush_pc;
                else t = br_target;
                redir_tgt  = {t[31:2], 2'b00};
                have_redir = 1'b1;
            end
            if (showing && (bus.if_ready || redir)) begin
                showing = 1'b0; expect_low = 1'b1;
                if (bus.if_ready) consumed++;
            end
            if (prev_req && !prev_gnt) begin
                tests_run++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
                    tests_failed++;
                    $display("FAIL addr_hold: req/addr=%b/%h required 1/%h", bus.imem_req, bus.imem_addr, prev_addr);
                end
            end
            if (bus.imem_req === 1'b1) begin
                tests_run++;
                if (bus.imem_addr[1:0] !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL addr_align: addr=%h required low bits 00", bus.imem_addr);
                end
            end
            if (idle_cnt > 80) begin
                tests_run++; tests_failed++;
                $display("FAIL watchdog: %0d cycles without presentation required <= 80", idle_cnt);
                idle_cnt = 0;
            end
        end
        prev_req  = (bus.imem_req === 1'b1) && !rst;
        prev_gnt  = bus.imem_gnt;
        prev_addr = bus.imem_addr;
        prev_rst  = rst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst = rst_s;
        bus.if_ready = ready_s;
        trap_req = trap_s;  trap_vec  = trap_v;
        flush_req = flush_s; flush_pc = flush_v;
        br_req = br_s;      br_target = br_v;
        mem_drive();
        @(negedge clk);
        monitor();
        cyc++;
        trap_s = 1'b0; flush_s = 1'b0; br_s = 1'b0;
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        repeat (3) tick();
        gnt_addr_q.delete(); gnt_cyc_q.delete();
        pres_pc_q.delete(); pres_cyc_q.delete();
        consumed = 0;
        rst_s = 1'b0;
        tick();
    endtask

    task automatic wait_gnt(input int budget, input string name);
        int n = 0;
        do begin tick(); n++; end while (bus.imem_gnt !== 1'b1 && n < budget);
        if (bus.imem_gnt !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL %s: no grant within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        do begin tick(); n++; end while (bus.if_valid !== 1'b1 && n < budget);
        if (bus.if_valid !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL %s: if_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic test_reset();
        mem_rand = 1'b0; gnt_delay = 0; rv_delay = 0; ready_s = 1'b1;
        rst_s = 1'b1;
        repeat (3) tick();
        chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'd0);
        chk("rst_pc", pc, RST_PC);
        rst_s = 1'b0;
        tick();
        chk("boot_no_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        chk("first_req", {31'b0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, RST_PC);
    endtask

    task automatic test_sequential();
        int boot_cyc, n;
        mem_rand = 1'b0; gnt_delay = 0; rv_delay = 0; ready_s = 1'b1;
        do_reset();
        boot_cyc = cyc - 1;
        n = 0;
        while (pres_pc_q.size() < 3 && n < 30) begin tick(); n++; end
        if (pres_pc_q.size() >= 3 && gnt_addr_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("seq_addr", gnt_addr_q[i], RST_PC + 32'(4 * i));
                chk("seq_if_pc", pres_pc_q[i], RST_PC + 32'(4 * i));
            end
            chk("seq_first_req_cycle", 32'(gnt_cyc_q[0] - boot_cyc), 32'd1);
            chk("seq_valid_latency", 32'(pres_cyc_q[0] - gnt_cyc_q[0]), 32'd2);
            chk("seq_period", 32'(gnt_cyc_q[1] - gnt_cyc_q[0]), 32'd3);
            chk("seq_period2", 32'(pres_cyc_q[2] - pres_cyc_q[1]), 32'd3);
        end else begin
            tests_run++; tests_failed++;
            $display("FAIL seq_progress: %0d presentations required 3", pres_pc_q.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, inst0;
        mem_rand = 1'b0; gnt_delay = 0; rv_delay = 0; ready_s = 1'b0;
        do_reset();
        wait_valid(20, "stall_wait");
        pc0 = bus.if_pc; inst0 = bus.if_inst;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'b0, bus.if_valid}, 32'd1);
            chk("stall_pc", bus.if_pc, pc0);
            chk("stall_inst", bus.if_inst, inst0);
            chk("stall_no_req", {31'b0, bus.imem_req}, 32'd0);
        end
        ready_s = 1'b1;
        wait_gnt(10, "stall_resume");
        chk("stall_next_addr", bus.imem_addr, pc0 + 32'd4);
    endtask

    task automatic test_branch_drop();
        mem_rand = 1'b0; gnt_delay = 0; rv_delay = 2; ready_s = 1'b1;
        do_reset();
        wait_gnt(10, "br_first_gnt");
        br_s = 1'b1; br_v = 32'h0000_0203;
        tick();
        wait_gnt(20, "br_second_gnt");
        chk("br_next_addr", bus.imem_addr, 32'h0000_0200);
        chk("br_nothing_shown", 32'(pres_pc_q.size()), 32'd0);
        wait_valid(20, "br_present");
        chk("br_if_pc", bus.if_pc, 32'h0000_0200);
        rv_delay = 0;
    endtask

    task automatic test_priority();
        mem_rand = 1'b0; gnt_delay = 0; rv_delay = 0; ready_s = 1'b0;
        do_reset();
        wait_valid(20, "pri_wait");
        trap_s = 1'b1;  trap_v = 32'h0000_0080;
        flush_s = 1'b1; flush_v = 32'h0000_0040;
        br_s = 1'b1;    br_v = 32'h0000_0010;
        tick();
        chk("pri_valid_during", {31'b0, bus.if_valid}, 32'd1);
        tick();
        chk("pri_req", {31'b0, bus.imem_req}, 32'd1);
        chk("pri_addr", bus.imem_addr, 32'h0000_0080);
    endtask

    task automatic test_gnt_wait_flush();
        logic got = 1'b0;
        mem_rand = 1'b0; gnt_delay = 3; rv_delay = 0; ready_s = 1'b1;
        do_reset();
        for (int i = 0; i < 10 && !got; i++) begin
            if (i == 0) begin flush_s = 1'b1; flush_v = 32'h0000_0040; end
            if (i == 2) begin flush_s = 1'b1; flush_v = 32'h0000_0060; end
            tick();
            chk("gw_addr_held", bus.imem_addr, RST_PC);
            got = (bus.imem_gnt === 1'b1);
        end
        chk("gw_granted", {31'b0, got}, 32'd1);
        wait_gnt(20, "gw_refetch");
        chk("gw_next_addr", bus.imem_addr, 32'h0000_0060);
        wait_valid(20, "gw_present");
        chk("gw_if_pc", bus.if_pc, 32'h0000_0060);
        gnt_delay = 0;
    endtask

    task automatic test_reset_mid_resp();
        int n = 0;
        mem_rand = 1'b0; gnt_delay = 0; rv_delay = 0; ready_s = 1'b1;
        do_reset();
        while (pres_pc_q.size() < 2 && n < 30) begin tick(); n++; end
        rv_delay = 4; keep_on_rst = 1'b1;
        wait_gnt(10, "rr_gnt");
        rv_delay = 0;
        tick();
        rst_s = 1'b1;
        tick(); tick();
        rst_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_no_valid", {31'b0, bus.if_valid}, 32'd0);
        end
        wait_valid(20, "rr_present");
        chk("rr_restart_pc", bus.if_pc, RST_PC);
        chk("rr_restart_inst", bus.if_inst, mem_word(RST_PC));
        keep_on_rst = 1'b0;
    endtask

    task automatic test_random();
        mem_rand = 1'b1; ready_s = 1'b1;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            ready_s = ($urandom_range(0, 9) < 7);
            trap_s  = ($urandom_range(0, 19) == 0); trap_v  = $urandom;
            flush_s = ($urandom_range(0, 15) == 0); flush_v = $urandom;
            br_s    = ($urandom_range(0, 11) == 0); br_v    = $urandom;
            tick();
        end
        tests_run++;
        if (consumed < 30) begin
            tests_failed++;
            $display("FAIL rand_progress: consumed=%0d required >= 30", consumed);
        end
        mem_rand = 1'b0;
    endtask

    initial begin
        rst = 1'b1; trap_req = 1'b0; flush_req = 1'b0; br_req = 1'b0;
        trap_vec = 0; flush_pc = 0; br_target = 0;
        bus.if_ready = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_drop();
        test_priority();
        test_gnt_wait_flush();
        test_reset_mid_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
